// File: rtl/fb_rect_filler.sv
// fb_rect_filler: fills a clipped rectangle of a frame buffer with one colour.
// One pixel is written per cycle in raster order. Every output is registered.
module fb_rect_filler #(
    parameter int unsigned FB_WIDTH   = 40,
    parameter int unsigned FB_HEIGHT  = 30,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic                  iStart,
    input  logic [5:0]            iX0,
    input  logic [4:0]            iY0,
    input  logic [5:0]            iW,
    input  logic [4:0]            iH,
    input  logic [5:0]            iColor,
    output logic                  oBusy,
    output logic                  oDone,
    output logic [ADDR_WIDTH-1:0] oAddr,
    output logic [DATA_WIDTH-1:0] oData,
    output logic                  oCs,
    output logic                  oWe,
    output logic                  oOe
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_FILL,
        S_DONE
    } state_t;

    localparam logic [6:0]            FBW_X   = 7'(FB_WIDTH);
    localparam logic [5:0]            FBH_Y   = 6'(FB_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] FBW_A   = ADDR_WIDTH'(FB_WIDTH);
    localparam logic [31:0]           FBW_VEC = 32'(FB_WIDTH);

    state_t                state_q, state_d;
    logic [5:0]            x0_q, x0_d;
    logic [4:0]            y0_q, y0_d;
    logic [5:0]            w_q, w_d;
    logic [4:0]            h_q, h_d;
    logic [5:0]            color_q, color_d;
    logic [6:0]            x_end_q, x_end_d;
    logic [5:0]            y_end_q, y_end_d;
    logic [5:0]            x_q, x_d;
    logic [4:0]            y_q, y_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic [ADDR_WIDTH-1:0] row_mult;
    logic [6:0]            x_sum, x_clip;
    logic [5:0]            y_sum, y_clip;
    logic [DATA_WIDTH-1:0] fill_word;
    logic                  last_col, last_row;

    // y0 * FB_WIDTH as a sum of shifted copies of y0, one per set bit of FB_WIDTH
    always_comb begin
        row_mult = '0;
        for (int unsigned i = 0; i < ADDR_WIDTH; i++) begin
            if (FBW_VEC[i]) begin
                row_mult = row_mult + (ADDR_WIDTH'(y0_q) << i);
            end
        end
    end

    // Clipped end coordinates, sums one bit wider than the operands
    always_comb begin
        x_sum     = {1'b0, x0_q} + {1'b0, w_q};
        y_sum     = {1'b0, y0_q} + {1'b0, h_q};
        x_clip    = (x_sum > FBW_X) ? FBW_X : x_sum;
        y_clip    = (y_sum > FBH_Y) ? FBH_Y : y_sum;
        fill_word = '0;
        fill_word[5:0] = color_q;
        last_col  = (({1'b0, x_q} + 7'd1) == x_end_q);
        last_row  = (({1'b0, y_q} + 6'd1) == y_end_q);
    end

    // Next-state and registered-output logic; outputs are prepared one cycle ahead
    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        w_d        = w_q;
        h_d        = h_q;
        color_d    = color_q;
        x_end_d    = x_end_q;
        y_end_d    = y_end_q;
        x_d        = x_q;
        y_d        = y_q;
        row_base_d = row_base_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        wr_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;

        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    x0_d    = iX0;
                    y0_d    = iY0;
                    w_d     = iW;
                    h_d     = iH;
                    color_d = iColor;
                    busy_d  = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                x_end_d = x_clip;
                y_end_d = y_clip;
                if (({1'b0, x0_q} >= x_clip) || ({1'b0, y0_q} >= y_clip)) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    x_d        = x0_q;
                    y_d        = y0_q;
                    row_base_d = row_mult;
                    addr_d     = row_mult + ADDR_WIDTH'(x0_q);
                    data_d     = fill_word;
                    wr_d       = 1'b1;
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                // x_q/y_q name the pixel on the bus now; the next one is set up here
                if (last_col && last_row) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (last_col) begin
                    x_d        = x0_q;
                    y_d        = y_q + 5'd1;
                    row_base_d = row_base_q + FBW_A;
                    addr_d     = row_base_q + FBW_A + ADDR_WIDTH'(x0_q);
                    wr_d       = 1'b1;
                end else begin
                    x_d    = x_q + 6'd1;
                    addr_d = row_base_q + ADDR_WIDTH'(x_q + 6'd1);
                    wr_d   = 1'b1;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, operand, counter and output registers with asynchronous clear
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= S_IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            color_q    <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            w_q        <= w_d;
            h_q        <= h_d;
            color_q    <= color_d;
            x_end_q    <= x_end_d;
            y_end_q    <= y_end_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign oBusy = busy_q;
    assign oDone = done_q;
    assign oAddr = addr_q;
    assign oData = data_q;
    assign oCs   = wr_q;
    assign oWe   = wr_q;
    assign oOe   = 1'b0;

endmodule

// File: tb/tb_fb_rect_filler.sv
// Self-checking bench for fb_rect_filler: expected write addresses are queued
// when a request is issued and popped against the writes the DUT performs.
module tb_fb_rect_filler;

    localparam int FBW = 40;
    localparam int FBH = 30;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iStart = 1'b0;
    logic [5:0]  iX0 = '0;
    logic [4:0]  iY0 = '0;
    logic [5:0]  iW = '0;
    logic [4:0]  iH = '0;
    logic [5:0]  iColor = '0;
    logic        oBusy, oDone, oCs, oWe, oOe;
    logic [10:0] oAddr;
    logic [7:0]  oData;

    fb_rect_filler #(
        .FB_WIDTH(40),
        .FB_HEIGHT(30),
        .ADDR_WIDTH(11),
        .DATA_WIDTH(8)
    ) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iStart(iStart),
        .iX0(iX0), .iY0(iY0), .iW(iW), .iH(iH), .iColor(iColor),
        .oBusy(oBusy), .oDone(oDone), .oAddr(oAddr), .oData(oData),
        .oCs(oCs), .oWe(oWe), .oOe(oOe)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int failures = 0;

    // scoreboard and observation records
    logic [10:0] exp_addr[$];
    logic [7:0]  exp_data;
    logic [10:0] obs_addr[$];
    logic [7:0]  obs_data[$];
    int          obs_cyc[$];
    logic        obs_busy[$];
    int          done_cyc, done_cnt, bus_bad;

    // Push the expected write sequence of a clipped rectangle
    task automatic expect_rect(input int x0, input int y0, input int w, input int h, input int col);
        int xe, ye;
        exp_addr.delete();
        xe = (x0 + w > FBW) ? FBW : x0 + w;
        ye = (y0 + h > FBH) ? FBH : y0 + h;
        for (int y = y0; y < ye; y++)
            for (int x = x0; x < xe; x++)
                exp_addr.push_back(11'(y * FBW + x));
        exp_data = 8'(col & 63);
    endtask

    // Called at a negedge; returns at the negedge of cycle T+1
    task automatic start_op(input int x0, input int y0, input int w, input int h, input int col);
        expect_rect(x0, y0, w, h, col);
        iX0 = 6'(x0); iY0 = 5'(y0); iW = 6'(w); iH = 5'(h); iColor = 6'(col);
        iStart = 1'b1;
        @(negedge iCLK);
        iStart = 1'b0;
        iX0 = '1; iY0 = '1; iW = '1; iH = '1; iColor = '0;
    endtask

    // Record DUT activity cycle by cycle (cycle 1 = T+1), stopping at the cycle after oDone
    task automatic capture(input int max_cyc, input int pulse_at);
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete(); obs_busy.delete();
        done_cyc = -1; done_cnt = 0; bus_bad = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            if (oWe === 1'b1) begin
                obs_addr.push_back(oAddr);
                obs_data.push_back(oData);
                obs_cyc.push_back(c);
            end
            obs_busy.push_back(oBusy);
            if (oCs !== oWe || oOe !== 1'b0) bus_bad++;
            if (oDone === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c == done_cyc + 1) break;
            iStart = (c == pulse_at);
            @(negedge iCLK);
        end
        iStart = 1'b0;
    endtask

    task automatic test_reset();
        iRST_N = 1'b0;
        repeat (3) @(negedge iCLK);
        checks++;
        if ({oBusy, oDone, oCs, oWe, oOe} !== 5'b0)
            begin failures++; $display("FAIL reset_ctrl: got %b expected 00000", {oBusy, oDone, oCs, oWe, oOe}); end
        checks++;
        if (oAddr !== 11'd0 || oData !== 8'd0)
            begin failures++; $display("FAIL reset_bus: addr=%0d data=%0h expected 0/0", oAddr, oData); end
        iRST_N = 1'b1;
        @(negedge iCLK);
    endtask

    // Basic, clipped, empty and off-screen rectangles
    task automatic test_fill_cases();
        int tbl[5][5] = '{'{2, 3, 4, 2, 'h30}, '{38, 29, 5, 3, 'h0F}, '{5, 5, 0, 7, 'h15},
                          '{50, 2, 3, 2, 'h3F}, '{10, 4, 3, 0, 'h2A}};
        for (int k = 0; k < 5; k++) begin
            int n, idx, bb;
            start_op(tbl[k][0], tbl[k][1], tbl[k][2], tbl[k][3], tbl[k][4]);
            capture(60, 0);
            n = exp_addr.size();
            checks++;
            if (obs_addr.size() != n)
                begin failures++; $display("FAIL case%0d_count: got %0d writes expected %0d", k, obs_addr.size(), n); end
            idx = 0;
            while (exp_addr.size() > 0 && obs_addr.size() > 0) begin
                logic [10:0] ea, oa; logic [7:0] od; int oc;
                ea = exp_addr.pop_front(); oa = obs_addr.pop_front();
                od = obs_data.pop_front(); oc = obs_cyc.pop_front();
                checks++;
                if (oa !== ea || od !== exp_data || oc != 2 + idx)
                    begin failures++; $display("FAIL case%0d_write%0d: addr=%0d data=%0h cyc=%0d expected %0d/%0h/%0d", k, idx, oa, od, oc, ea, exp_data, 2 + idx); end
                idx++;
            end
            checks++;
            if (done_cyc != 2 + n || done_cnt != 1)
                begin failures++; $display("FAIL case%0d_done: cycle=%0d pulses=%0d expected %0d/1", k, done_cyc, done_cnt, 2 + n); end
            bb = 0;
            foreach (obs_busy[i]) if (obs_busy[i] !== (i + 1 <= 2 + n)) bb++;
            checks++;
            if (bb != 0 || bus_bad != 0)
                begin failures++; $display("FAIL case%0d_busy: busy_errs=%0d bus_errs=%0d expected 0/0", k, bb, bus_bad); end
        end
    endtask

    // iStart during FILL is ignored; iStart in the cycle after oDone is accepted
    task automatic test_back_to_back();
        int n, idx;
        start_op(2, 3, 4, 2, 'h30);
        capture(60, 5);
        n = exp_addr.size();
        checks++;
        if (obs_addr.size() != n || done_cnt != 1 || done_cyc != 10)
            begin failures++; $display("FAIL collide: writes=%0d done=%0d@%0d expected %0d/1@10", obs_addr.size(), done_cnt, done_cyc, n); end
        idx = 0;
        while (exp_addr.size() > 0 && obs_addr.size() > 0) begin
            logic [10:0] ea, oa;
            ea = exp_addr.pop_front(); oa = obs_addr.pop_front();
            void'(obs_data.pop_front()); void'(obs_cyc.pop_front());
            checks++;
            if (oa !== ea)
                begin failures++; $display("FAIL collide_write%0d: addr=%0d expected %0d", idx, oa, ea); end
            idx++;
        end
        start_op(0, 0, 3, 1, 'h3F);
        capture(60, 0);
        n = exp_addr.size();
        checks++;
        if (obs_addr.size() != n || done_cyc != 2 + n)
            begin failures++; $display("FAIL b2b: writes=%0d done@%0d expected %0d@%0d", obs_addr.size(), done_cyc, n, 2 + n); end
        idx = 0;
        while (exp_addr.size() > 0 && obs_addr.size() > 0) begin
            logic [10:0] ea, oa; logic [7:0] od;
            ea = exp_addr.pop_front(); oa = obs_addr.pop_front(); od = obs_data.pop_front();
            void'(obs_cyc.pop_front());
            checks++;
            if (oa !== ea || od !== exp_data)
                begin failures++; $display("FAIL b2b_write%0d: addr=%0d data=%0h expected %0d/%0h", idx, oa, od, ea, exp_data); end
            idx++;
        end
    endtask

    // Reset after the 3rd write, then a full-screen fill right after release
    task automatic test_reset_midop();
        int wcnt, bad, n, idx, bb;
        start_op(2, 3, 4, 2, 'h30);
        wcnt = 0;
        for (int c = 1; c <= 20 && wcnt < 3; c++) begin
            if (oWe === 1'b1) wcnt++;
            if (wcnt < 3) @(negedge iCLK);
        end
        checks++;
        if (wcnt != 3)
            begin failures++; $display("FAIL midop_reach: writes=%0d expected 3", wcnt); end
        iRST_N = 1'b0;
        #1;
        checks++;
        if (oWe !== 1'b0 || oBusy !== 1'b0 || oCs !== 1'b0 || oAddr !== 11'd0)
            begin failures++; $display("FAIL midop_async: we=%b busy=%b cs=%b addr=%0d expected 0/0/0/0", oWe, oBusy, oCs, oAddr); end
        bad = 0;
        repeat (3) begin
            @(negedge iCLK);
            if (oDone !== 1'b0 || oWe !== 1'b0) bad++;
        end
        iRST_N = 1'b1;
        checks++;
        if (bad != 0)
            begin failures++; $display("FAIL midop_quiet: errs=%0d expected 0", bad); end
        start_op(0, 0, 40, 30, 'h21);
        capture(1300, 0);
        n = exp_addr.size();
        checks++;
        if (obs_addr.size() != n || done_cyc != 1202 || done_cnt != 1)
            begin failures++; $display("FAIL full_fill: writes=%0d done=%0d@%0d expected %0d/1@1202", obs_addr.size(), done_cnt, done_cyc, n); end
        idx = 0;
        while (exp_addr.size() > 0 && obs_addr.size() > 0) begin
            logic [10:0] ea, oa; logic [7:0] od; int oc;
            ea = exp_addr.pop_front(); oa = obs_addr.pop_front();
            od = obs_data.pop_front(); oc = obs_cyc.pop_front();
            checks++;
            if (oa !== ea || od !== exp_data || oc != 2 + idx)
                begin failures++; $display("FAIL full_write%0d: addr=%0d data=%0h cyc=%0d expected %0d/%0h/%0d", idx, oa, od, oc, ea, exp_data, 2 + idx); end
            idx++;
        end
        bb = 0;
        foreach (obs_busy[i]) if (obs_busy[i] !== (i + 1 <= 1202)) bb++;
        checks++;
        if (bb != 0 || bus_bad != 0)
            begin failures++; $display("FAIL full_busy: busy_errs=%0d bus_errs=%0d expected 0/0", bb, bus_bad); end
    endtask

    initial begin
        @(negedge iCLK);
        test_reset();
        test_fill_cases();
        test_back_to_back();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_rect_filler.md
FB_RECT_FILLER -- requirements
Module: fb_rect_filler

Interface
REQ-001 Parameter FB_WIDTH, default 40, frame-buffer columns.
REQ-002 Parameter FB_HEIGHT, default 30, frame-buffer rows.
REQ-003 Parameter ADDR_WIDTH, default 11, frame-buffer address width.
REQ-004 Parameter DATA_WIDTH, default 8, frame-buffer word width (bits 5:0 = RRGGBB, bits 7:6 zero).
REQ-005 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-006 iCLK  input  1  block clock, shared with the frame buffer.
REQ-007 iRST_N  input  1  asynchronous active-low reset.
REQ-008 iStart  input  1  request pulse; sampled only in IDLE.
REQ-009 iX0 / iY0  input  6 / 5  top-left corner (column / row).
REQ-010 iW / iH  input  6 / 5  width / height in pixels.
REQ-011 iColor  input  6  RRGGBB fill colour.
REQ-012 oBusy  output  1  high from the cycle after an accepted iStart through the DONE cycle.
REQ-013 oDone  output  1  one-cycle completion pulse.
REQ-014 oAddr  output  ADDR_WIDTH  frame-buffer write address, row*FB_WIDTH + column.
REQ-015 oData  output  DATA_WIDTH  write data, {2'b00, latched colour}.
REQ-016 oCs / oWe / oOe  output  1 each  frame-buffer chip select / write enable / output enable.

Function
REQ-017 FSM states: IDLE, SETUP, FILL, DONE; all outputs registered.
REQ-018 IDLE: iStart=1 latches iX0, iY0, iW, iH and iColor; the next state is SETUP. Otherwise the FSM stays in IDLE.
REQ-019 iStart SHALL be ignored in every state other than IDLE. The latched operands SHALL NOT change while busy.
REQ-020 SETUP computes the clipped end values: x_end = min(x0+w, FB_WIDTH) and y_end = min(y0+h, FB_HEIGHT). Sums are computed 1 bit wider, so there is no wrap-around.
REQ-021 SETUP: if x0 >= x_end or y0 >= y_end (zero size or fully off-screen), the next state is DONE. Otherwise the next state is FILL, with x=x0, y=y0 and row_base=y0*FB_WIDTH.
REQ-022 row_base SHALL be formed without a multiplier, by an iterative add or a constant-shift sum.
REQ-023 FILL: every cycle writes exactly one pixel, with oCs=1, oWe=1, oAddr=row_base+x and oData={2'b00,colour}.
REQ-024 Scan order SHALL be raster order: x increments. When x=x_end-1, x reloads x0, y increments and row_base increases by FB_WIDTH.
REQ-025 The last write is at (x_end-1, y_end-1); the next state is DONE.
REQ-026 DONE: oDone=1 for exactly one cycle, oCs=oWe=0, and the next state is IDLE.
REQ-027 oOe SHALL be 0 at all times (the port is write-only).
REQ-028 oCs and oWe SHALL be 0 in every state except FILL.
REQ-029 Latency: accepted iStart at cycle T gives the first write at T+2 and oDone at T+2+N, where N = clipped pixel count. For an empty rectangle, oDone is at T+2.
REQ-030 The block SHALL return to IDLE in the cycle after oDone, and a new iStart SHALL be accepted there.

Reset
REQ-031 On iRST_N=0, asynchronously and regardless of state: FSM=IDLE; oBusy=0, oDone=0, oCs=0, oWe=0, oOe=0; oAddr=0, oData=0; internal counters=0.
REQ-032 Reset asserted mid-FILL SHALL drop oWe within the same cycle. No further writes occur and no oDone is produced.
REQ-033 After reset release, the first iStart SHALL be accepted on the first rising edge.

Verification
REQ-034 Basic fill: x0=2, y0=3, w=4, h=2, colour=0x30, iStart at T -> writes to addresses 122,123,124,125,162,163,164,165 at T+2..T+9, oData=0x30, oDone at T+10.
REQ-035 Clipping: x0=38, y0=29, w=5, h=3, colour=0x0F -> exactly two writes (1198, 1199), oDone at T+4.
REQ-036 Empty request: w=0 (any h) -> no cycle with oWe=1, oBusy high T+1..T+2, oDone at T+2.
REQ-037 Busy collision: second iStart pulsed during FILL of the REQ-034 rectangle -> ignored; exactly 8 writes, one oDone. iStart in the cycle after oDone -> accepted.
REQ-038 Reset mid-op: iRST_N=0 after the 3rd write of the REQ-034 rectangle -> oWe=0 and oBusy=0 immediately, oDone never pulses; a new full-screen fill (0,0,40,30) afterwards -> 1200 writes to 0..1199, oDone at T+1202.
